aging_warning_gen: RTL and testbench
====================================

# aging_warning_gen

Window-based mismatch detector that sits directly upstream of the aging-sensor event counter and drives its `warning_signal` input. Each cycle it compares a main-path capture flop with its guardband shadow flop and counts mismatches over a fixed measurement window. At the end of a window whose mismatch count reaches a threshold, it emits exactly one single-cycle warning pulse. The downstream counter therefore advances by exactly one per degraded window, never once per raw mismatch.

## Interface
- `WIN_LEN`, default 16: cycles per measurement window; legal range 2..255.
- `HIT_TH`, default 3: minimum mismatches in one window that qualify a warning; legal range 1..`WIN_LEN`.
- `CNT_W`, default 8: width of the mismatch count; must satisfy 2^`CNT_W` > `WIN_LEN`.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; starts and keeps the block measuring.
- `clear` in 1: synchronous abort; returns the block to IDLE.
- `main_q` in 1: main-path capture flop output, synchronous to `clk`.
- `shadow_q` in 1: guardband shadow flop output, synchronous to `clk`.
- `warning_signal` out 1: one-cycle pulse marking a qualifying window; feeds the event counter.
- `window_done` out 1: one-cycle pulse at the end of every completed window.
- `last_count` out `CNT_W`: mismatch count of the most recently completed window.
- `busy` out 1: high in states ARMED, MEASURE and REPORT.

## Operation
- Input stage: `main_q` and `shadow_q` are registered once. `mismatch = main_r ^ shadow_r`.
- FSM states: IDLE, ARMED, MEASURE, REPORT.
- IDLE: holds while `enable`=0. Moves to ARMED on `enable`=1.
- ARMED: lasts one cycle and flushes the input registers. The window counter `win` and the running count `hits` are both set to 0. Moves to MEASURE.
- MEASURE: lasts exactly `WIN_LEN` cycles.
  - Each cycle: `win++`, and `hits++` when `mismatch`=1.
  - `hits` saturates at `WIN_LEN`.
  - Moves to REPORT after the `WIN_LEN`-th sample.
- REPORT: lasts one cycle.
  - `window_done`=1.
  - `last_count` <= `hits`.
  - `warning_signal`=1 only if `hits` >= `HIT_TH`.
  - Next state is MEASURE with `win` and `hits` zeroed if `enable`=1, else IDLE.
- Consecutive windows run back to back with no ARMED cycle in between. Period = `WIN_LEN`+1 cycles.
- `enable` falling during MEASURE aborts the window: go to IDLE, no pulse, `last_count` unchanged.
- `clear`=1 in any state forces IDLE with `win`=0, `hits`=0, `last_count`=0 and no pulse. `clear` has priority over `enable`.
- `warning_signal` and `window_done` are registered outputs. They are never high for two consecutive cycles.

## Timing
- Reset (`reset_n`=0): state=IDLE, `warning_signal`=0, `window_done`=0, `last_count`=0, `busy`=0, input registers=0, `win`=0, `hits`=0.
- Reset asserted mid-window discards that window immediately, with no pulse.
- Latency, when `enable` rises at edge E:
  - ARMED at E+1.
  - The first sample counted is the input present at E+1, registered at E+2.
  - MEASURE occupies E+2..E+1+`WIN_LEN`.
  - REPORT pulse at E+2+`WIN_LEN`.
- A mismatch on the inputs at edge t is counted at edge t+1.
- A mismatch presented during the REPORT cycle belongs to the next window.
- Boundary rules:
  - `hits` == `HIT_TH` exactly qualifies.
  - `hits` = `HIT_TH`-1 does not qualify.
  - `HIT_TH` = `WIN_LEN` requires a mismatch on every sample.
- `clear` and `enable` together in IDLE: stay in IDLE.

## Test plan
- Reset, then `enable`=1 with `main_q`=`shadow_q` for 3 windows (`WIN_LEN`=16, `HIT_TH`=3) -> `window_done` pulses every 17 cycles, `warning_signal` never pulses, `last_count`=0.
- 3 mismatch cycles in window 1, then 2 mismatch cycles in window 2 -> window 1: `warning_signal` pulse and `last_count`=3; window 2: no pulse and `last_count`=2.
- Constant mismatch for 2 windows -> `last_count`=16, one `warning_signal` pulse per window (2 total), never two adjacent high cycles.
- `enable` dropped at window cycle 10 after 5 mismatches -> IDLE next cycle, no pulse, `last_count` keeps its previous value, `busy`=0.
- `clear` pulse in REPORT of a qualifying window -> no `warning_signal`, `last_count`=0, IDLE; re-armed by `enable`, next window is counted from 0.
- `reset_n` asserted asynchronously mid-MEASURE with 4 mismatches already counted -> all outputs 0 immediately; after release with `enable`=1, first REPORT appears `WIN_LEN`+2 cycles later.

Source files
------------

// File: rtl/aging_warning_gen_if.sv
// Bundle between the aging warning generator and its environment:
// control levels, sensor flop samples and window results.
interface aging_warning_gen_if #(
   parameter int CNT_W = 8
);
   logic             enable;
   logic             clear;
   logic             main_q;
   logic             shadow_q;
   logic             warning_signal;
   logic             window_done;
   logic [CNT_W-1:0] last_count;
   logic             busy;

   modport master (
      output enable,
      output clear,
      output main_q,
      output shadow_q,
      input  warning_signal,
      input  window_done,
      input  last_count,
      input  busy
   );

   modport slave (
      input  enable,
      input  clear,
      input  main_q,
      input  shadow_q,
      output warning_signal,
      output window_done,
      output last_count,
      output busy
   );
endinterface

// File: rtl/aging_warning_gen.sv
// Window-based main/shadow mismatch counter that emits one warning
// pulse per degraded measurement window.
module aging_warning_gen #(
   parameter int WIN_LEN = 16,
   parameter int HIT_TH  = 3,
   parameter int CNT_W   = 8
) (
   input logic               clk,
   input logic               reset_n,
   aging_warning_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      MEASURE,
      REPORT
   } state_t;

   localparam logic [CNT_W-1:0] WIN_MAX  = CNT_W'(WIN_LEN);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] TH       = CNT_W'(HIT_TH);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state;
   state_t           state_nx;
   logic             main_r;
   logic             shadow_r;
   logic             mismatch;
   logic [CNT_W-1:0] win;
   logic [CNT_W-1:0] hits;
   logic [CNT_W-1:0] last_cnt;
   logic             warn_r;
   logic             done_r;

   assign mismatch = main_r ^ shadow_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (bus.clear) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.enable) state_nx = ARMED;
            end
            ARMED: begin
               state_nx = MEASURE;
            end
            MEASURE: begin
               if (!bus.enable)          state_nx = IDLE;
               else if (win == WIN_LAST) state_nx = REPORT;
            end
            REPORT: begin
               state_nx = bus.enable ? MEASURE : IDLE;
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   // Held at zero while idle so ARMED starts from a flushed pair.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_r   <= 1'b0;
         shadow_r <= 1'b0;
      end else if (bus.clear || state == IDLE) begin
         main_r   <= 1'b0;
         shadow_r <= 1'b0;
      end else begin
         main_r   <= bus.main_q;
         shadow_r <= bus.shadow_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win      <= '0;
         hits     <= '0;
         last_cnt <= '0;
         warn_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         warn_r <= 1'b0;
         done_r <= 1'b0;
         if (bus.clear) begin
            win      <= '0;
            hits     <= '0;
            last_cnt <= '0;
         end else begin
            unique case (state)
               MEASURE: begin
                  win <= win + ONE;
                  if (mismatch && hits != WIN_MAX) hits <= hits + ONE;
               end
               REPORT: begin
                  done_r   <= 1'b1;
                  warn_r   <= (hits >= TH);
                  last_cnt <= hits;
                  win      <= '0;
                  hits     <= '0;
               end
               default: begin
                  win  <= '0;
                  hits <= '0;
               end
            endcase
         end
      end
   end

   assign bus.warning_signal = warn_r;
   assign bus.window_done    = done_r;
   assign bus.last_count     = last_cnt;
   assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_aging_warning_gen.sv
// Scoreboard bench for aging_warning_gen: expected window results are
// queued as stimulus is driven and matched against each window_done.
module tb_aging_warning_gen;

   localparam int WIN = 16;
   localparam int TH  = 3;
   localparam int CW  = 8;

   typedef struct {
      int   cyc;
      int   cnt;
      logic warn;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   int   next_pulse;
   logic prev_warn;
   exp_t sb[$];

   aging_warning_gen_if #(.CNT_W(CW)) bus ();

   aging_warning_gen #(
      .WIN_LEN(WIN),
      .HIT_TH (TH),
      .CNT_W  (CW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (bus.warning_signal) begin
            check("warn_adjacent", {31'd0, prev_warn}, 32'd0);
            check("warn_with_done", {31'd0, bus.window_done}, 32'd1);
         end
         if (bus.window_done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", {31'd0, bus.window_done}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("last_count", {24'd0, bus.last_count}, e.cnt);
               check("warning", {31'd0, bus.warning_signal}, {31'd0, e.warn});
               check("pulse_cycle", cyc, e.cyc);
            end
         end
      end
      prev_warn = bus.warning_signal;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic quiet();
      logic m;
      m = 1'($urandom_range(0, 1));
      bus.main_q   = m;
      bus.shadow_q = m;
   endtask

   task automatic start();
      bus.enable = 1'b1;
      @(posedge clk);
      #1;
      next_pulse = cyc + 2 + WIN;
   endtask

   task automatic samples(input logic [15:0] pat, input int n);
      logic m;
      for (int i = 0; i < n; i++) begin
         m = 1'($urandom_range(0, 1));
         bus.main_q   = m;
         bus.shadow_q = m ^ pat[i];
         step(1);
      end
      quiet();
   endtask

   task automatic window(input logic [15:0] pat, input bit push);
      exp_t e;
      if (push) begin
         e.cyc  = next_pulse;
         e.cnt  = $countones(pat);
         e.warn = (e.cnt >= TH);
         sb.push_back(e);
      end
      next_pulse += WIN + 1;
      samples(pat, WIN);
      step(1);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      prev_warn     = 1'b0;
      next_pulse    = 0;
      reset_n       = 1'b0;
      bus.enable    = 1'b0;
      bus.clear     = 1'b0;
      bus.main_q    = 1'b0;
      bus.shadow_q  = 1'b0;
      step(3);
      check("rst_warn", {31'd0, bus.warning_signal}, 32'd0);
      check("rst_done", {31'd0, bus.window_done}, 32'd0);
      check("rst_count", {24'd0, bus.last_count}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      reset_n = 1'b1;
      step(2);

      // clean windows back to back
      start();
      check("busy_armed", {31'd0, bus.busy}, 32'd1);
      window(16'h0000, 1'b1);
      window(16'h0000, 1'b1);
      window(16'h0000, 1'b1);
      bus.enable = 1'b0;
      step(3);

      // threshold hit exactly, then one short of it
      start();
      window(16'h0111, 1'b1);
      window(16'h8001, 1'b1);
      bus.enable = 1'b0;
      step(3);

      // saturated mismatch
      start();
      window(16'hFFFF, 1'b1);
      window(16'hFFFF, 1'b1);
      bus.enable = 1'b0;
      step(3);

      // abort mid-window via enable
      start();
      samples(16'h0155, 10);
      bus.enable = 1'b0;
      step(1);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_count", {24'd0, bus.last_count}, 32'd16);
      step(WIN + 3);
      check("abort_count_hold", {24'd0, bus.last_count}, 32'd16);

      // clear during REPORT of a qualifying window
      start();
      window(16'h00FF, 1'b0);
      bus.clear = 1'b1;
      step(1);
      bus.clear = 1'b0;
      check("clr_busy", {31'd0, bus.busy}, 32'd0);
      check("clr_count", {24'd0, bus.last_count}, 32'd0);
      check("clr_warn", {31'd0, bus.warning_signal}, 32'd0);
      start();
      window(16'h0007, 1'b1);
      bus.enable = 1'b0;
      step(3);

      // clear beats enable in IDLE
      bus.clear  = 1'b1;
      bus.enable = 1'b1;
      step(2);
      check("clr_en_idle", {31'd0, bus.busy}, 32'd0);
      bus.clear  = 1'b0;
      bus.enable = 1'b0;
      step(2);

      // asynchronous reset mid-window
      start();
      samples(16'h000F, 6);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_warn", {31'd0, bus.warning_signal}, 32'd0);
      check("arst_done", {31'd0, bus.window_done}, 32'd0);
      check("arst_count", {24'd0, bus.last_count}, 32'd0);
      check("arst_busy", {31'd0, bus.busy}, 32'd0);
      step(1);
      reset_n = 1'b1;
      start();
      window(16'h1000, 1'b1);
      bus.enable = 1'b0;
      step(4);

      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
